// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structs, opcodes and bus width constants.
package tlul_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [3:0]        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_adapter_reg.sv
// tlul_adapter_reg: single-outstanding TL-UL to register-strobe adapter.
module tlul_adapter_reg
  import tlul_pkg::*;
#(
  parameter int RegAw = 8,
  parameter int RegDw = TL_DW
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [RegDw-1:0]   wdata_o,
  output logic [RegDw/8-1:0] be_o,
  input  logic [RegDw-1:0]   rdata_i,
  input  logic               error_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e              state_q;
  logic                get_q, re_q, we_q, dv_q, err_q;
  logic [TL_SZW-1:0]   size_q;
  logic [TL_AIW-1:0]   source_q;
  logic [RegAw-1:0]    addr_q;
  logic [RegDw/8-1:0]  mask_q;
  logic [RegDw-1:0]    wdata_q, rdata_q;
  logic                legal, is_get, unused_param;
  assign unused_param = ^tl_i.a_param;
  assign is_get = tl_i.a_opcode == Get;
  assign legal = (tl_i.a_opcode inside {PutFullData, PutPartialData, Get}) &&
                 tl_i.a_size == 2'd2 && tl_i.a_address[1:0] == 2'b00 &&
                 (tl_i.a_address >> RegAw) == '0 &&
                 !(tl_i.a_opcode == PutFullData && tl_i.a_mask != '1);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      get_q    <= 1'b0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (state_q == IDLE) begin
      if (tl_i.a_valid) begin
        state_q  <= legal ? ACCESS : RESP;
        get_q    <= is_get;
        re_q     <= legal && is_get;
        we_q     <= legal && !is_get;
        dv_q     <= !legal;
        err_q    <= !legal;
        size_q   <= tl_i.a_size;
        source_q <= tl_i.a_source;
        addr_q   <= tl_i.a_address[RegAw-1:0];
        mask_q   <= tl_i.a_mask;
        wdata_q  <= tl_i.a_data;
        rdata_q  <= '0;
      end
    end else if (state_q == ACCESS) begin
      state_q <= RESP;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      dv_q    <= 1'b1;
      err_q   <= error_i;
      rdata_q <= (get_q && !error_i) ? rdata_i : '0;
    end else if (tl_i.d_ready) begin
      state_q <= IDLE;
      dv_q    <= 1'b0;
    end
  end
  // Handshake and strobe outputs are forced low for the whole reset cycle.
  assign re_o    = re_q & ~reset_i;
  assign we_o    = we_q & ~reset_i;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign be_o    = mask_q;
  assign tl_o = '{
    d_valid:  dv_q & ~reset_i,
    d_opcode: get_q ? AccessAckData : AccessAck,
    d_param:  '0,
    d_size:   size_q,
    d_source: source_q,
    d_sink:   '0,
    d_data:   rdata_q,
    d_user:   '0,
    d_error:  err_q,
    a_ready:  state_q == IDLE && !reset_i
  };
endmodule

// File: tb/tb_tlul_adapter_reg.sv
// tb_tlul_adapter_reg: directed and random TL-UL transactions against a rule-based model.
module tb_tlul_adapter_reg;
  import tlul_pkg::*;
  logic        clk = 1'b0;
  logic        reset_i;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o, snap;
  logic        re_o, we_o, error_i;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o, rdata_i;
  logic [3:0]  be_o;
  int vec = 0, miss = 0, n_re = 0, n_we = 0;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  tlul_adapter_reg dut (
    .clk_i(clk), .reset_i(reset_i), .tl_i(tl_i), .tl_o(tl_o), .re_o(re_o), .we_o(we_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i), .error_i(error_i)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (re_o) n_re = n_re + 1;
    if (we_o) n_we = n_we + 1;
    if (re_o || we_o) begin
      s_addr = addr_o;
      s_wdata = wdata_o;
      s_be = be_o;
    end
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vec++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic wait_accept();
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tl_o.a_ready) begin ok = 1'b1; break; end
    end
    chk("accept", ok, 1);
  endtask
  task automatic wait_dvalid();
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tl_o.d_valid) begin ok = 1'b1; break; end
    end
    chk("d_valid", ok, 1);
  endtask
  task automatic set_req(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_opcode = tl_a_op_e'(op);
    tl_i.a_param = 3'($urandom);
    tl_i.a_size = sz;
    tl_i.a_address = addr;
    tl_i.a_mask = mask;
    tl_i.a_data = data;
    tl_i.a_source = src;
    tl_i.a_valid = 1'b1;
  endtask
  // Called just after a rising edge; returns just after a rising edge.
  task automatic txn(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                     input logic [31:0] rd, input logic err);
    logic legal, exp_re, exp_we;
    legal = (op == 0 || op == 1 || op == 4) && sz == 2 && addr % 4 == 0 && addr < 256 &&
            !(op == 0 && mask != 4'hF);
    exp_re = legal && op == 4;
    exp_we = legal && op != 4;
    rdata_i = rd;
    error_i = err;
    tl_i.d_ready = 1'b1;
    n_re = 0;
    n_we = 0;
    set_req(op, sz, addr, mask, data, src);
    wait_accept();
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    wait_dvalid();
    chk("n_re", n_re, exp_re);
    chk("n_we", n_we, exp_we);
    if (exp_re || exp_we) chk("addr_o", s_addr, addr[7:0]);
    if (exp_we) chk("wdata_be", {s_wdata, s_be}, {data, mask});
    chk("d_opcode", tl_o.d_opcode, op == 4 ? 1 : 0);
    chk("d_error", tl_o.d_error, !legal || err);
    chk("d_data", tl_o.d_data, (legal && op == 4 && !err) ? rd : 32'h0);
    chk("d_meta", {tl_o.d_size, tl_o.d_source, tl_o.d_param, tl_o.d_sink, tl_o.d_user},
        {sz, src, 3'b0, 1'b0, 4'b0});
    @(posedge clk); #1;
  endtask
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd3, 3'd2, 3'd5, 3'd1};
    logic [1:0]  sz;
    logic [31:0] addr;
    reset_i = 1'b1;
    tl_i = '0;
    rdata_i = '0;
    error_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {tl_o.a_ready, tl_o.d_valid, re_o, we_o}, 4'b0000);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_release_a_ready", tl_o.a_ready, 1);
    @(posedge clk); #1;
    txn(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3, 32'hCAFEF00D, 1'b0);
    txn(3'd1, 2'd2, 32'h04, 4'b0011, 32'h12345678, 8'd1, 32'h0, 1'b0);
    txn(3'd4, 2'd2, 32'h02, 4'hF, 32'h0, 8'd4, 32'h11111111, 1'b0);
    txn(3'd0, 2'd2, 32'h08, 4'h7, 32'hAAAA5555, 8'd5, 32'h0, 1'b0);
    txn(3'd3, 2'd2, 32'h0C, 4'hF, 32'h0, 8'd6, 32'h22222222, 1'b0);
    txn(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, 8'd7, 32'h33333333, 1'b0);
    txn(3'd4, 2'd2, 32'h08, 4'hF, 32'h0, 8'd5, 32'hDEADBEEF, 1'b1);
    txn(3'd0, 2'd2, 32'hFC, 4'hF, 32'h87654321, 8'd9, 32'h0, 1'b1);
    // Back-pressure: response held while a new request waits.
    rdata_i = 32'h55AA00FF;
    error_i = 1'b0;
    tl_i.d_ready = 1'b0;
    n_re = 0;
    n_we = 0;
    set_req(3'd4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd2);
    wait_accept();
    wait_dvalid();
    snap = tl_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_a_ready", tl_o.a_ready, 0);
      chk("stall_stable", tl_o === snap, 1);
    end
    chk("stall_data", tl_o.d_data, 32'h55AA00FF);
    chk("stall_strobes", n_re + n_we, 1);
    @(posedge clk); #1;
    tl_i.d_ready = 1'b1;
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release", {tl_o.d_valid, tl_o.a_ready}, 2'b01);
    chk("stall_strobes_after", n_re + n_we, 1);
    @(posedge clk); #1;
    // Reset while the access cycle is in progress.
    n_re = 0;
    n_we = 0;
    set_req(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd8);
    wait_accept();
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst_access_out", {tl_o.d_valid, tl_o.a_ready, re_o, we_o}, 4'b0000);
    @(posedge clk);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_release", {tl_o.d_valid, tl_o.a_ready}, 2'b01);
    chk("rst_mid_strobes", n_re + n_we, 0);
    @(posedge clk); #1;
    txn(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd8, 32'h0BADF00D, 1'b0);
    for (int k = 0; k < 40; k++) begin
      sz = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd2;
      addr = ($urandom_range(0, 5) == 0) ? $urandom : {24'h0, 8'($urandom) & 8'hFC};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom);
      txn(ops[$urandom_range(0, 7)], sz, addr,
          $urandom_range(0, 1) ? 4'hF : 4'($urandom), $urandom, 8'($urandom),
          $urandom, $urandom_range(0, 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
